// File: rtl/rnd_sched_pkg.sv
// rnd_sched_pkg: shared FSM state encoding and default widths for the rounding scheduler
//   NREQ_DEF   - default requester count
//   DW_IN_DEF  - default input word width
//   DW_RND_DEF - default number of LSBs removed by rounding
//   state_t    - output register state (EMPTY=0, FULL=1)
package rnd_sched_pkg;
    localparam int NREQ_DEF   = 4;
    localparam int DW_IN_DEF  = 10;
    localparam int DW_RND_DEF = 2;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/rnd_sched_if.sv
// rnd_sched_if: requester handshake and result handshake of the rounding scheduler
//   i_req_vld/i_req_din/o_req_rdy - per-requester valid, packed words, one-hot accept
//   o_vld/o_dout/o_id/o_ovf/i_rdy - result valid, rounded word, source id, carry lost, downstream accept
//   slave  - scheduler side; master - requesters plus downstream consumer
interface rnd_sched_if import rnd_sched_pkg::*; #(
    parameter int NREQ   = NREQ_DEF,
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_RND = DW_RND_DEF,
    parameter int DW_OUT = DW_IN - DW_RND,
    parameter int IDW    = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       i_req_vld;
    logic [NREQ*DW_IN-1:0] i_req_din;
    logic [NREQ-1:0]       o_req_rdy;
    logic                  o_vld;
    logic [DW_OUT-1:0]     o_dout;
    logic [IDW-1:0]        o_id;
    logic                  o_ovf;
    logic                  i_rdy;
    modport slave (
        input  i_req_vld, i_req_din, i_rdy,
        output o_req_rdy, o_vld, o_dout, o_id, o_ovf
    );
    modport master (
        output i_req_vld, i_req_din, i_rdy,
        input  o_req_rdy, o_vld, o_dout, o_id, o_ovf
    );
endinterface

// File: rtl/rnd.sv
// rnd: round-half-up of a word by dropping DW_RND LSBs, result wraps modulo 2^(DW_IN-DW_RND)
//   din  - input word
//   dout - upper bits plus the highest dropped bit
module rnd import rnd_sched_pkg::*; #(
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_RND = DW_RND_DEF
) (
    input  logic [DW_IN-1:0]        din,
    output logic [DW_IN-DW_RND-1:0] dout
);
    assign dout = din[DW_IN-1:DW_RND] + (DW_IN-DW_RND)'(din[DW_RND-1]);
endmodule

// File: rtl/rnd_sched.sv
// rnd_sched: round-robin arbiter feeding one shared rounding unit with a one-deep output register
//   i_clk - clock
//   i_rst - asynchronous active-high reset
//   bus   - requester and result handshakes (slave side of rnd_sched_if)
module rnd_sched import rnd_sched_pkg::*; #(
    parameter int NREQ   = NREQ_DEF,
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_RND = DW_RND_DEF,
    parameter int DW_OUT = DW_IN - DW_RND,
    parameter int IDW    = $clog2(NREQ)
) (
    input logic         i_clk,
    input logic         i_rst,
    rnd_sched_if.slave  bus
);
    state_t            state;
    logic [IDW-1:0]    ptr, gidx, idx;
    logic              found, allow, grant, ovf_nxt, ovf_q;
    logic [DW_IN-1:0]  din_sel;
    logic [DW_OUT-1:0] rnd_out, dout_q;
    logic [IDW-1:0]    id_q;
    // first valid requester at ptr, ptr+1, ... modulo NREQ
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!found && bus.i_req_vld[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end
    // refill is allowed in the same cycle the held result drains
    assign allow         = !i_rst && (state == EMPTY || bus.i_rdy);
    assign grant         = allow && found;
    assign bus.o_req_rdy = grant ? NREQ'(1) << gidx : '0;
    assign din_sel       = bus.i_req_din[gidx*DW_IN +: DW_IN];
    // carry out of the increment is lost only when the kept bits are all ones
    assign ovf_nxt       = &din_sel[DW_IN-1:DW_RND] & din_sel[DW_RND-1];
    rnd #(.DW_IN(DW_IN), .DW_RND(DW_RND)) u_rnd (.din(din_sel), .dout(rnd_out));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= EMPTY;
            ptr    <= '0;
            dout_q <= '0;
            id_q   <= '0;
            ovf_q  <= 1'b0;
        end else if (grant) begin
            state  <= FULL;
            ptr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            dout_q <= rnd_out;
            id_q   <= gidx;
            ovf_q  <= ovf_nxt;
        end else if (bus.i_rdy) begin
            state  <= EMPTY;
        end
    end
    assign bus.o_vld  = state == FULL;
    assign bus.o_dout = dout_q;
    assign bus.o_id   = id_q;
    assign bus.o_ovf  = ovf_q;
endmodule

// File: tb/tb_rnd_sched.sv
// tb_rnd_sched: directed vectors with hand-computed expectations for rnd_sched
module tb_rnd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    rnd_sched_if bus ();
    rnd_sched dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic outs(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id, input logic o);
        chk({tag, ".vld"}, 32'(bus.o_vld), 32'(v));
        chk({tag, ".dout"}, 32'(bus.o_dout), 32'(d));
        chk({tag, ".id"}, 32'(bus.o_id), 32'(id));
        chk({tag, ".ovf"}, 32'(bus.o_ovf), 32'(o));
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set_din(input int k, input logic [9:0] v);
        bus.i_req_din[k*10 +: 10] = v;
    endtask
    initial begin
        bus.i_req_vld = 4'b0001;
        bus.i_req_din = '0;
        bus.i_rdy     = 1'b1;
        set_din(0, 10'b0000000110);
        @(negedge clk);
        chk("rst.req_rdy", 32'(bus.o_req_rdy), 0);
        outs("rst", 0, 8'h00, 0, 0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("t1.req_rdy", 32'(bus.o_req_rdy), 32'b0001);
        tick;
        bus.i_req_vld = '0;
        @(negedge clk);
        outs("t1", 1, 8'h02, 0, 0);
        chk("t1.req_rdy_idle", 32'(bus.o_req_rdy), 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_din(k, 10'((k + 1) * 4 + 2));
        bus.i_req_vld = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("rr%0d.req_rdy", c), 32'(bus.o_req_rdy), 32'(1 << (c % 4)));
            if (c > 0) outs($sformatf("rr%0d", c), 1, 8'((c - 1) % 4 + 2), 2'((c - 1) % 4), 0);
            tick;
        end
        bus.i_req_vld = '0;
        @(negedge clk);
        outs("rr_last", 1, 8'h05, 3, 0);
        tick;
        set_din(1, 10'h155);
        bus.i_req_vld = 4'b0010;
        bus.i_rdy     = 1'b0;
        @(negedge clk);
        chk("st.req_rdy1", 32'(bus.o_req_rdy), 32'b0010);
        tick;
        bus.i_req_vld = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("st%0d.req_rdy", c), 32'(bus.o_req_rdy), 0);
            outs($sformatf("st%0d", c), 1, 8'h55, 1, 0);
            tick;
        end
        bus.i_rdy = 1'b1;
        @(negedge clk);
        chk("st.req_rdy2", 32'(bus.o_req_rdy), 32'b0100);
        tick;
        bus.i_req_vld = '0;
        @(negedge clk);
        outs("st.refill", 1, 8'h04, 2, 0);
        tick;
        set_din(3, 10'h3FE);
        bus.i_req_vld = 4'b1000;
        @(negedge clk);
        chk("ovf.req_rdy1", 32'(bus.o_req_rdy), 32'b1000);
        tick;
        set_din(3, 10'h3FD);
        @(negedge clk);
        outs("ovf.3fe", 1, 8'h00, 3, 1);
        chk("ovf.req_rdy2", 32'(bus.o_req_rdy), 32'b1000);
        tick;
        bus.i_req_vld = '0;
        bus.i_rdy     = 1'b0;
        @(negedge clk);
        outs("ovf.3fd", 1, 8'hFF, 3, 0);
        #1;
        rst = 1'b1;
        #1;
        outs("arst", 0, 8'h00, 0, 0);
        tick;
        rst = 1'b0;
        bus.i_req_vld = 4'b1001;
        bus.i_rdy     = 1'b1;
        @(negedge clk);
        chk("arst.vld_after", 32'(bus.o_vld), 0);
        chk("arst.req_rdy0", 32'(bus.o_req_rdy), 32'b0001);
        tick;
        @(negedge clk);
        outs("arst.r0", 1, 8'h02, 0, 0);
        chk("arst.req_rdy3", 32'(bus.o_req_rdy), 32'b1000);
        tick;
        bus.i_req_vld = '0;
        @(negedge clk);
        outs("arst.r3", 1, 8'hFF, 3, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
